// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: Q16.16 sample format and default convolution output geometry.
// Also holds a small width helper used when sizing counters and memory addresses.
package cnn_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int FRAC_WIDTH  = 16;
  localparam int LINE_LENGTH = 158;
  localparam int N_LINES     = 106;

  // Index width for a range of `depth` entries, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/max_pool_stream_if.sv
// Sample stream bundle: one data word qualified by a valid strobe, no backpressure.
interface max_pool_stream_if #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;

  modport master (output data, output valid);
  modport slave  (input  data, input  valid);
endinterface

// File: rtl/pool_line_buffer.sv
// Half-line store for 2x2 pooling: pair maxima of an even row, read back on the following odd row.
// Synchronous write, combinational read, no reset so it maps onto RAM.
module pool_line_buffer
  import cnn_pkg::addr_width;
#(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int DEPTH      = cnn_pkg::LINE_LENGTH / 2,
  parameter int ADDR_W     = addr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/max_pool_stream.sv
// Streaming 2x2 stride-2 signed max pooling over a raster-order convolution output.
// Trailing odd column/row are consumed and dropped; frame_done_o marks the last sample of a frame.
module max_pool_stream
  import cnn_pkg::addr_width;
#(
  parameter int DATA_WIDTH  = cnn_pkg::DATA_WIDTH,
  parameter int LINE_LENGTH = cnn_pkg::LINE_LENGTH,
  parameter int N_LINES     = cnn_pkg::N_LINES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  max_pool_stream_if.slave  smp_i,
  max_pool_stream_if.master pool_o,
  output logic              frame_done_o
);
  localparam int HALF   = LINE_LENGTH / 2;
  localparam int COL_W  = addr_width(LINE_LENGTH);
  localparam int ROW_W  = addr_width(N_LINES);
  localparam int ADDR_W = addr_width(HALF);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] pair_q, data_q;
  logic                  valid_q, done_q;
  logic [DATA_WIDTH-1:0] pair_max, half_max, result;
  logic [ADDR_W-1:0]     half_idx;
  logic                  last_col, last_row, wr_en, emit;

  // Odd columns/rows are always inside the pooled area, so the low bits alone gate write/emit.
  always_comb begin
    last_col = (col_q == COL_W'(LINE_LENGTH - 1));
    last_row = (row_q == ROW_W'(N_LINES - 1));
    half_idx = ADDR_W'(col_q >> 1);
    pair_max = ($signed(smp_i.data) > $signed(pair_q)) ? smp_i.data : pair_q;
    result   = ($signed(half_max) > $signed(pair_max)) ? half_max : pair_max;
    wr_en    = smp_i.valid & ~row_q[0] & col_q[0];
    emit     = smp_i.valid &  row_q[0] & col_q[0];
    col_d    = last_col ? '0 : col_q + 1'b1;
    row_d    = row_q;
    if (last_col) row_d = last_row ? '0 : row_q + 1'b1;
  end

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HALF),
    .ADDR_W     (ADDR_W)
  ) u_line (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (half_idx),
    .wdata_i (pair_max),
    .raddr_i (half_idx),
    .rdata_o (half_max)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= emit;
      done_q  <= smp_i.valid & last_col & last_row;
      if (emit) data_q <= result;
      if (smp_i.valid) begin
        col_q <= col_d;
        row_q <= row_d;
        if (!col_q[0]) pair_q <= smp_i.data;
      end
    end
  end

  assign pool_o.data   = data_q;
  assign pool_o.valid  = valid_q;
  assign frame_done_o  = done_q;
endmodule
